// File: rtl/sccb_cfg_pkg.sv
// Shared definitions for the table-driven SCCB configuration sequencer.
package sccb_cfg_pkg;

  localparam int unsigned ENTRY_W = 18;
  localparam int unsigned OP_MSB  = 17;
  localparam int unsigned OP_LSB  = 16;
  localparam int unsigned SUB_MSB = 15;
  localparam int unsigned SUB_LSB = 8;
  localparam int unsigned DAT_MSB = 7;
  localparam int unsigned DAT_LSB = 0;

  localparam logic [7:0] CHIPID_SUB_HI = 8'h0A;
  localparam logic [7:0] CHIPID_SUB_LO = 8'h0B;

  typedef enum logic [1:0] {
    OP_WR  = 2'd0,
    OP_WRV = 2'd1,
    OP_DLY = 2'd2,
    OP_END = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_VERIFY = 2'd1,
    ERR_CHIPID = 2'd2
  } err_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ID_RD1,
    ST_ID_RD2,
    ST_FETCH,
    ST_DECODE,
    ST_WRITE,
    ST_VREAD,
    ST_CHECK,
    ST_DELAY,
    ST_NEXT,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/sccb_cfg_delay.sv
// Delay-entry down-counter. A loaded count of N expires after max(N,1) ticks;
// the stored value is N-1 so that o_zero marks the final tick.
module sccb_cfg_delay #(
  parameter int unsigned DELAY_W = 16
) (
  input  logic               PCLK,
  input  logic               PRESETN,
  input  logic               i_load,
  input  logic [DELAY_W-1:0] i_val,
  input  logic               i_tick,
  output logic               o_zero
);

  logic [DELAY_W-1:0] r_cnt;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= (i_val == '0) ? '0 : i_val - DELAY_W'(1);
    end else if (i_tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - DELAY_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sccb_cfg_seq.sv
// Table-driven SCCB configuration sequencer.
// Optional chip-ID check before the table walk: define SCCB_CFG_CHIPID_CHECK_EN.
module sccb_cfg_seq
  import sccb_cfg_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned IDX_W       = $clog2(NUM_ENTRIES),
  parameter logic [7:0]  DEV_ID      = 8'h42,
  parameter int unsigned DELAY_W     = 16,
  parameter int unsigned MAX_RETRY   = 3,
  parameter logic [15:0] CHIP_ID     = 16'h7673
) (
  input  logic             PCLK,
  input  logic             PRESETN,
  input  logic             mid_pulse,
  input  logic             go,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [17:0]      tbl_entry,
  output logic             sccb_start,
  output logic             sccb_rw,
  output logic [7:0]       sccb_id,
  output logic [7:0]       sccb_sub,
  output logic [7:0]       sccb_wdata,
  input  logic [7:0]       sccb_rdata,
  input  logic             sccb_done,
  output logic             busy,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic [IDX_W-1:0] err_idx,
  output logic [1:0]       err_code
);

  localparam logic [7:0] RD_ID = DEV_ID | 8'h01;

  state_e           r_state, w_nxt_state;
  op_e              r_op, w_nxt_op;
  logic [IDX_W-1:0] r_idx, w_nxt_idx, r_eidx, w_nxt_eidx;
  logic             r_start, w_nxt_start, r_rw, w_nxt_rw;
  logic [7:0]       r_id, w_nxt_id, r_sub, w_nxt_sub, r_wdata, w_nxt_wdata;
  logic [7:0]       r_rdata, w_nxt_rdata, r_id_hi, w_nxt_id_hi;
  logic             r_busy, w_nxt_busy, r_done, w_nxt_done, r_err, w_nxt_err;
  logic [1:0]       r_ecode, w_nxt_ecode;
  logic [2:0]       r_retry, w_nxt_retry;
  logic             w_dly_load, w_dly_zero;

  sccb_cfg_delay #(.DELAY_W(DELAY_W)) u_delay (
    .PCLK    (PCLK),
    .PRESETN (PRESETN),
    .i_load  (w_dly_load),
    .i_val   (DELAY_W'(tbl_entry[SUB_MSB:DAT_LSB])),
    .i_tick  (mid_pulse && (r_state == ST_DELAY)),
    .o_zero  (w_dly_zero)
  );

`ifndef SCCB_CFG_CHIPID_CHECK_EN
  logic w_unused_chip_id;
  assign w_unused_chip_id = ^CHIP_ID;
`endif

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state <= ST_IDLE;
      r_op    <= OP_WR;
      r_idx   <= '0;
      r_eidx  <= '0;
      r_start <= 1'b0;
      r_rw    <= 1'b0;
      r_id    <= '0;
      r_sub   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_id_hi <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ecode <= ERR_NONE;
      r_retry <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_op    <= w_nxt_op;
      r_idx   <= w_nxt_idx;
      r_eidx  <= w_nxt_eidx;
      r_start <= w_nxt_start;
      r_rw    <= w_nxt_rw;
      r_id    <= w_nxt_id;
      r_sub   <= w_nxt_sub;
      r_wdata <= w_nxt_wdata;
      r_rdata <= w_nxt_rdata;
      r_id_hi <= w_nxt_id_hi;
      r_busy  <= w_nxt_busy;
      r_done  <= w_nxt_done;
      r_err   <= w_nxt_err;
      r_ecode <= w_nxt_ecode;
      r_retry <= w_nxt_retry;
    end
  end

  // Read states raise start one tick after entry so a done still held from
  // the preceding transaction is never mistaken for the read's completion.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_op    = r_op;
    w_nxt_idx   = r_idx;
    w_nxt_eidx  = r_eidx;
    w_nxt_start = r_start;
    w_nxt_rw    = r_rw;
    w_nxt_id    = r_id;
    w_nxt_sub   = r_sub;
    w_nxt_wdata = r_wdata;
    w_nxt_rdata = r_rdata;
    w_nxt_id_hi = r_id_hi;
    w_nxt_busy  = r_busy;
    w_nxt_done  = r_done;
    w_nxt_err   = r_err;
    w_nxt_ecode = r_ecode;
    w_nxt_retry = r_retry;
    w_dly_load  = 1'b0;
    if (mid_pulse) begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (go) begin
            w_nxt_done  = 1'b0;
            w_nxt_err   = 1'b0;
            w_nxt_ecode = ERR_NONE;
            w_nxt_eidx  = '0;
            w_nxt_idx   = '0;
            w_nxt_retry = '0;
            w_nxt_busy  = 1'b1;
`ifdef SCCB_CFG_CHIPID_CHECK_EN
            w_nxt_start = 1'b1;
            w_nxt_rw    = 1'b1;
            w_nxt_id    = RD_ID;
            w_nxt_sub   = CHIPID_SUB_HI;
            w_nxt_state = ST_ID_RD1;
`else
            w_nxt_state = ST_FETCH;
`endif
          end
        end
`ifdef SCCB_CFG_CHIPID_CHECK_EN
        ST_ID_RD1: begin
          if (sccb_done) begin
            w_nxt_id_hi = sccb_rdata;
            w_nxt_start = 1'b0;
            w_nxt_state = ST_ID_RD2;
          end
        end
        ST_ID_RD2: begin
          if (!r_start) begin
            w_nxt_start = 1'b1;
            w_nxt_sub   = CHIPID_SUB_LO;
          end else if (sccb_done) begin
            w_nxt_start = 1'b0;
            if ({r_id_hi, sccb_rdata} == CHIP_ID) begin
              w_nxt_state = ST_FETCH;
            end else begin
              w_nxt_err   = 1'b1;
              w_nxt_ecode = ERR_CHIPID;
              w_nxt_eidx  = '0;
              w_nxt_busy  = 1'b0;
              w_nxt_state = ST_ERR;
            end
          end
        end
`endif
        ST_FETCH: w_nxt_state = ST_DECODE;
        ST_DECODE: begin
          w_nxt_op = op_e'(tbl_entry[OP_MSB:OP_LSB]);
          case (op_e'(tbl_entry[OP_MSB:OP_LSB]))
            OP_WR, OP_WRV: begin
              w_nxt_id    = DEV_ID;
              w_nxt_sub   = tbl_entry[SUB_MSB:SUB_LSB];
              w_nxt_wdata = tbl_entry[DAT_MSB:DAT_LSB];
              w_nxt_rw    = 1'b0;
              w_nxt_start = 1'b1;
              w_nxt_state = ST_WRITE;
            end
            OP_DLY: begin
              w_dly_load  = 1'b1;
              w_nxt_state = ST_DELAY;
            end
            OP_END: begin
              w_nxt_done  = 1'b1;
              w_nxt_busy  = 1'b0;
              w_nxt_state = ST_DONE;
            end
          endcase
        end
        ST_WRITE: begin
          if (sccb_done) begin
            w_nxt_start = 1'b0;
            if (r_op == OP_WRV) begin
              w_nxt_id    = RD_ID;
              w_nxt_rw    = 1'b1;
              w_nxt_state = ST_VREAD;
            end else begin
              w_nxt_state = ST_NEXT;
            end
          end
        end
        ST_VREAD: begin
          if (!r_start) begin
            w_nxt_start = 1'b1;
          end else if (sccb_done) begin
            w_nxt_start = 1'b0;
            w_nxt_rdata = sccb_rdata;
            w_nxt_state = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (r_rdata == r_wdata) begin
            w_nxt_retry = '0;
            w_nxt_state = ST_NEXT;
          end else if (r_retry < 3'(MAX_RETRY)) begin
            w_nxt_retry = r_retry + 3'd1;
            w_nxt_state = ST_DECODE;
          end else begin
            w_nxt_err   = 1'b1;
            w_nxt_ecode = ERR_VERIFY;
            w_nxt_eidx  = r_idx;
            w_nxt_busy  = 1'b0;
            w_nxt_state = ST_ERR;
          end
        end
        ST_DELAY: begin
          if (w_dly_zero) w_nxt_state = ST_NEXT;
        end
        ST_NEXT: begin
          if (r_idx == IDX_W'(NUM_ENTRIES - 1)) begin
            w_nxt_done  = 1'b1;
            w_nxt_busy  = 1'b0;
            w_nxt_state = ST_DONE;
          end else begin
            w_nxt_idx   = r_idx + IDX_W'(1);
            w_nxt_state = ST_FETCH;
          end
        end
        default: w_nxt_state = ST_IDLE;
      endcase
    end
  end

  assign tbl_idx    = r_idx;
  assign sccb_start = r_start;
  assign sccb_rw    = r_rw;
  assign sccb_id    = r_id;
  assign sccb_sub   = r_sub;
  assign sccb_wdata = r_wdata;
  assign busy       = r_busy;
  assign cfg_done   = r_done;
  assign cfg_err    = r_err;
  assign err_idx    = r_eidx;
  assign err_code   = r_ecode;

endmodule

// File: tb/tb_sccb_cfg_seq.sv
// Bench for sccb_cfg_seq (4-entry table). Define SCCB_CFG_CHIPID_CHECK_EN to
// also exercise the chip-ID pre-check.
module tb_sccb_cfg_seq;
  import sccb_cfg_pkg::*;

  localparam int unsigned NE   = 4;
  localparam int unsigned IW   = 2;
  localparam int unsigned MAXR = 3;
  localparam logic [7:0]  DEV  = 8'h42;
`ifdef SCCB_CFG_CHIPID_CHECK_EN
  localparam int ID_RDS = 2;
`else
  localparam int ID_RDS = 0;
`endif

  logic          PCLK = 1'b0, PRESETN = 1'b0, mid_pulse = 1'b0, go = 1'b0;
  logic [17:0]   tbl_entry = '0;
  logic [7:0]    sccb_rdata = '0;
  logic          sccb_done = 1'b0;
  logic [IW-1:0] tbl_idx, err_idx;
  logic          sccb_start, sccb_rw, busy, cfg_done, cfg_err;
  logic [7:0]    sccb_id, sccb_sub, sccb_wdata;
  logic [1:0]    err_code;

  sccb_cfg_seq #(
    .NUM_ENTRIES (NE),
    .IDX_W       (IW),
    .DEV_ID      (DEV),
    .DELAY_W     (16),
    .MAX_RETRY   (MAXR),
    .CHIP_ID     (16'h7673)
  ) dut (
    .PCLK       (PCLK),
    .PRESETN    (PRESETN),
    .mid_pulse  (mid_pulse),
    .go         (go),
    .tbl_idx    (tbl_idx),
    .tbl_entry  (tbl_entry),
    .sccb_start (sccb_start),
    .sccb_rw    (sccb_rw),
    .sccb_id    (sccb_id),
    .sccb_sub   (sccb_sub),
    .sccb_wdata (sccb_wdata),
    .sccb_rdata (sccb_rdata),
    .sccb_done  (sccb_done),
    .busy       (busy),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .err_idx    (err_idx),
    .err_code   (err_code)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic       rw;
    logic [7:0] id;
    logic [7:0] sub;
    logic [7:0] wd;
  } txn_t;

  txn_t        exp_q[$];
  logic [17:0] rom [NE];
  logic [7:0]  mem [256];
  logic [7:0]  chip_hi = 8'h76, chip_lo = 8'h73;
  int          n_checks = 0, n_fail = 0;
  int          tick_cnt = 0, last_done_tick = 0, last_gap = 0, txn_cnt = 0;
  int          bad_reads = 0, mp_mode = 0;
  logic        exp_done, exp_err;
  logic [1:0]  exp_code;
  logic [IW-1:0] exp_eidx, exp_tidx;
  logic [34:0] w_outs;

  assign w_outs = {tbl_idx, sccb_start, sccb_rw, sccb_id, sccb_sub, sccb_wdata,
                   busy, cfg_done, cfg_err, err_idx, err_code};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  function automatic txn_t mk(input logic rw, input logic [7:0] id, input logic [7:0] sub,
                              input logic [7:0] wd);
    txn_t t;
    t.rw = rw; t.id = id; t.sub = sub; t.wd = wd;
    return t;
  endfunction

  // Reference: walk the table by the op rules; the first fail_k verify reads
  // return corrupted data.
  task automatic model(input int fail_k);
    int bad;
    logic [1:0] op;
    logic [7:0] s, d;
    bad = fail_k;
    exp_done = 0; exp_err = 0; exp_code = 0; exp_eidx = '0; exp_tidx = '0;
`ifdef SCCB_CFG_CHIPID_CHECK_EN
    exp_q.push_back(mk(1'b1, DEV | 8'h01, 8'h0A, 8'h00));
    exp_q.push_back(mk(1'b1, DEV | 8'h01, 8'h0B, 8'h00));
    if ({chip_hi, chip_lo} != 16'h7673) begin
      exp_err = 1; exp_code = 2;
      return;
    end
`endif
    for (int i = 0; i < NE; i++) begin
      op = rom[i][17:16]; s = rom[i][15:8]; d = rom[i][7:0];
      exp_tidx = IW'(i);
      if (op == OP_WR) begin
        exp_q.push_back(mk(1'b0, DEV, s, d));
      end else if (op == OP_WRV) begin
        for (int a = 0; a <= MAXR; a++) begin
          exp_q.push_back(mk(1'b0, DEV, s, d));
          exp_q.push_back(mk(1'b1, DEV | 8'h01, s, 8'h00));
          if (bad == 0) break;
          bad--;
          if (a == MAXR) begin
            exp_err = 1; exp_code = 1; exp_eidx = IW'(i);
            return;
          end
        end
      end else if (op == OP_END) begin
        exp_done = 1;
        return;
      end
    end
    exp_done = 1;
  endtask

  // Tick generator, registered table ROM, CoreSCCB BFM and scoreboard monitor.
  initial begin : bfm
    logic          tick_was;
    logic [IW-1:0] idx_prev;
    bit            busy_b;
    int            lat;
    txn_t          t, e;
    idx_prev = '0; busy_b = 0; lat = 0;
    forever begin
      @(posedge PCLK);
      tick_was = mid_pulse;
      #1;
      if (!PRESETN) begin
        busy_b = 0; sccb_done = 1'b0; idx_prev = '0;
      end else if (tick_was) begin
        tick_cnt++;
        tbl_entry = rom[idx_prev];
        if (sccb_done) begin
          sccb_done = 1'b0; busy_b = 0; last_done_tick = tick_cnt;
        end else if (busy_b) begin
          lat--;
          if (lat == 0) sccb_done = 1'b1;
        end else if (sccb_start) begin
          busy_b = 1; lat = $urandom_range(1, 4); txn_cnt++;
          last_gap = tick_cnt - last_done_tick;
          t = mk(sccb_rw, sccb_id, sccb_sub, sccb_rw ? 8'h00 : sccb_wdata);
          if (!sccb_rw) mem[sccb_sub] = sccb_wdata;
          else if (sccb_sub == 8'h0A) sccb_rdata = chip_hi;
          else if (sccb_sub == 8'h0B) sccb_rdata = chip_lo;
          else if (bad_reads > 0) begin
            sccb_rdata = ~mem[sccb_sub]; bad_reads--;
          end else sccb_rdata = mem[sccb_sub];
          if (exp_q.size() == 0) begin
            fail_now("unexpected_sccb_txn");
          end else begin
            e = exp_q.pop_front();
            check("sccb_txn", 64'(t), 64'(e));
          end
        end
      end
      idx_prev = tbl_idx;
      mid_pulse = (mp_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
    end
  end

  task automatic wait_busy(input logic lvl, input int max_cyc, input string nm);
    bit ok;
    ok = 0;
    for (int c = 0; c < max_cyc; c++) begin
      if (busy === lvl) begin ok = 1; break; end
      @(posedge PCLK); #2;
    end
    if (!ok) fail_now(nm);
  endtask

  task automatic run_seq(input int fail_k, input string nm);
    mp_mode = $urandom_range(0, 3);
    model(fail_k);
    bad_reads = fail_k;
    @(posedge PCLK); #2;
    go = 1'b1;
    wait_busy(1'b1, 300, {nm, " start"});
    go = 1'b0;
    wait_busy(1'b0, 20000, {nm, " finish"});
    repeat (40) @(posedge PCLK);
    #2;
    check({nm, " queue_empty"}, 64'(exp_q.size()), 64'd0);
    check({nm, " status"}, {busy, cfg_done, cfg_err, err_code, err_idx, tbl_idx},
          {1'b0, exp_done, exp_err, exp_code, exp_eidx, exp_tidx});
    exp_q.delete();
  endtask

  function automatic logic [17:0] ent(input logic [1:0] op, input logic [7:0] s, input logic [7:0] d);
    return {op, s, d};
  endfunction

  task automatic rand_table();
    int r;
    for (int i = 0; i < NE; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      rom[i] = ent(OP_WR, 8'($urandom_range(16, 255)), 8'($urandom));
      else if (r < 7) rom[i] = ent(OP_WRV, 8'($urandom_range(16, 255)), 8'($urandom));
      else if (r < 9) rom[i] = ent(OP_DLY, 8'h00, 8'($urandom_range(0, 12)));
      else            rom[i] = ent(OP_END, 8'h00, 8'h00);
    end
  endtask

  initial begin : stim
    int base, n, start_cnt;
    bit ok;
    for (int i = 0; i < NE; i++) rom[i] = ent(OP_END, 8'h00, 8'h00);
    repeat (4) @(posedge PCLK);
    #2;
    check("reset_outputs", 64'(w_outs), 64'd0);
    PRESETN = 1'b1;

    rom[0] = ent(OP_WR, 8'h12, 8'h80); rom[1] = ent(OP_WR, 8'h11, 8'h01);
    rom[2] = ent(OP_END, 8'h00, 8'h00); rom[3] = ent(OP_WR, 8'h55, 8'h55);
    run_seq(0, "two_writes");

    rom[0] = ent(OP_WRV, 8'h40, 8'hD0); rom[1] = ent(OP_END, 8'h00, 8'h00);
    run_seq(0, "verify_ok");
    run_seq(2, "verify_retry");
    run_seq(100, "verify_fail");

    rom[0] = ent(OP_WR, 8'h20, 8'h11); rom[2] = ent(OP_WR, 8'h21, 8'h22);
    rom[3] = ent(OP_END, 8'h00, 8'h00);
    rom[1] = ent(OP_DLY, 8'h00, 8'h00);
    run_seq(0, "delay0");
    base = last_gap;
    for (int k = 0; k < 3; k++) begin
      n = (k == 0) ? 5 : $urandom_range(1, 20);
      rom[1] = ent(OP_DLY, 8'(n >> 8), 8'(n));
      run_seq(0, "delayN");
      check("delay_ticks", 64'(last_gap - base), 64'(n - 1));
    end

    for (int i = 0; i < NE; i++) rom[i] = ent(OP_WR, 8'(8'h30 + i), 8'($urandom));
    run_seq(0, "no_end");

    rom[3] = ent(OP_END, 8'h00, 8'h00);
    model(0);
    start_cnt = txn_cnt;
    go = 1'b1;
    ok = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge PCLK); #3;
      if (busy) go = 1'b0;
      if (txn_cnt == start_cnt + ID_RDS + 2) begin ok = 1; break; end
    end
    if (!ok) fail_now("reset_wait_2nd_write");
    PRESETN = 1'b0;
    #1;
    check("async_reset_outputs", 64'(w_outs), 64'd0);
    go = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge PCLK);
    #2;
    PRESETN = 1'b1;
    run_seq(0, "after_reset");

`ifdef SCCB_CFG_CHIPID_CHECK_EN
    chip_lo = 8'h72;
    run_seq(0, "chipid_bad");
    chip_lo = 8'h73;
    run_seq(0, "chipid_ok");
`endif

    for (int t = 0; t < 25; t++) begin
      rand_table();
      run_seq(($urandom_range(0, 7) == 0) ? 100 : $urandom_range(0, 5), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d failed", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sccb_cfg_seq.md
Name:
sccb_cfg_seq

Overview:
- Table-driven SCCB configuration sequencer that replaces the hard-coded camera init FSM.
- Walks an external registered table of N entries (write, write-with-verify, delay, end), drives CoreSCCB's start/rw/id_addr/sub_addr/data_in, and retries failed verifies.
- Reports done/error status to the APB wrapper.
- Sits between the APB wrapper, clock_divider (mid_pulse) and CoreSCCB.

Parameters:
- NUM_ENTRIES, 16, table depth (2..256).
- IDX_W, $clog2(NUM_ENTRIES), table index width.
- DEV_ID, 8'h42, SCCB write ID; read ID is DEV_ID|1.
- DELAY_W, 16, width of delay-entry count in mid_pulse ticks.
- MAX_RETRY, 3, verify retries per entry before error (0..7).
- CHIP_ID, 16'h7673, expected {PID,VER}; used only with the optional feature.

Ports:
- PCLK  in  1  system clock
- PRESETN  in  1  async active-low reset
- mid_pulse  in  1  SCCB tick from clock_divider; the FSM advances only when high
- go  in  1  start sequence; level sampled in IDLE/DONE/ERR
- tbl_idx  out  IDX_W  table read address
- tbl_entry  in  18  {op[1:0], sub_addr[7:0], data[7:0]}, valid one mid_pulse after tbl_idx changes
- sccb_start  out  1  to CoreSCCB start
- sccb_rw  out  1  0=write, 1=read
- sccb_id  out  8  to CoreSCCB id_addr
- sccb_sub  out  8  to CoreSCCB sub_addr
- sccb_wdata  out  8  to CoreSCCB data_in
- sccb_rdata  in  8  from CoreSCCB data_out
- sccb_done  in  1  from CoreSCCB done
- busy  out  1  sequence in progress
- cfg_done  out  1  sticky; table reached END or ran past the last index
- cfg_err  out  1  sticky; verify failure after retries
- err_idx  out  IDX_W  index of the failing entry
- err_code  out  2  0 none, 1 verify mismatch, 2 chip-ID mismatch

Behaviour:
- Reset: every output 0; state IDLE; retry count 0.
- Ops (sccb_cfg_pkg): OP_WR=0, OP_WRV=1, OP_DLY=2, OP_END=3.
- All state transitions qualify on mid_pulse. sccb_start is held high until sccb_done is sampled with mid_pulse, then dropped in that same tick.
- IDLE: on go, clear cfg_done, cfg_err, err_code, err_idx and tbl_idx; busy=1; go to FETCH.
- FETCH: one tick of table latency; go to DECODE.
- DECODE, by op:
  - WR/WRV: load sccb_id=DEV_ID, sub, wdata, rw=0; go to WRITE.
  - DLY: load counter={sub,data} truncated to DELAY_W; go to DELAY.
  - END: go to DONE.
- WRITE: on done, WR goes to NEXT; WRV goes to VREAD with sccb_id=DEV_ID|1, rw=1.
- VREAD: on done, capture sccb_rdata; go to CHECK.
- CHECK:
  - Match: clear retry count; go to NEXT.
  - Mismatch and retry<MAX_RETRY: retry++; go to DECODE (rewrite).
  - Otherwise: cfg_err=1, err_code=1, err_idx=tbl_idx; go to ERR.
- DELAY: decrement per mid_pulse; at 0 go to NEXT. A count of 0 elapses in one tick.
- NEXT: if tbl_idx==NUM_ENTRIES-1, go to DONE (implicit END, no wrap); else tbl_idx++ and go to FETCH.
- DONE/ERR: busy=0, status held; go re-enters IDLE flow on the next tick.
- go while busy is ignored.
- PRESETN low mid-transaction: immediate reset. sccb_start drops asynchronously; CoreSCCB shares the reset.
- sccb_done arriving without mid_pulse is not acted on until a tick in which both are high. CoreSCCB holds done through the tick.

Optional Feature:
- Macro SCCB_CFG_CHIPID_CHECK_EN.
- Defined: after IDLE, perform reads of sub 0x0A then 0x0B (states ID_RD1, ID_RD2) before the first FETCH.
  - Mismatch with CHIP_ID: cfg_err=1, err_code=2, err_idx=0, ERR; no table writes issued.
  - Match: proceed to FETCH.
- Not defined: IDLE goes straight to FETCH; err_code 2 never occurs.

Decomposition:
- Package sccb_cfg_pkg: op encodings, entry field positions/width (18), err_code values, state encoding.
- One sub-module sccb_cfg_delay: DELAY_W down-counter with load/tick/zero, clocked by PCLK, reset by PRESETN.
- Table ROM stays outside the block.

Test Plan:
- Table {WR 12/80, WR 11/01, END}, go=1 → two write transactions to id 0x42 with subs 0x12 then 0x11; cfg_done=1, busy=0, cfg_err=0.
- WRV 40/D0 with BFM returning 0xD0 → one write plus one read (id 0x43); cfg_done=1.
- WRV 40/D0 with BFM always returning 0x00, MAX_RETRY=3 → exactly 4 writes and 4 reads; cfg_err=1, err_code=1, err_idx=0; no further SCCB traffic.
- DLY count 5 between two WRs → exactly 5 mid_pulse ticks with sccb_start low between them.
- NUM_ENTRIES=4 with no END entry → 4 entries executed, cfg_done=1, tbl_idx stays 3. Assert PRESETN low during the 2nd write → all outputs 0 immediately; a later go restarts from index 0.
- With SCCB_CFG_CHIPID_CHECK_EN, BFM returns 0x76, 0x72 → err_code=2, zero write transactions. Returning 0x76, 0x73 instead → table proceeds normally.
